// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman round controller.
// Optional streak bonus is enabled by defining HANGMAN_BONUS_EN.
package hangman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } state_e;

    // Keyboard code for "start"; it is also the first code past the letters.
    localparam logic [4:0] START_CODE   = 5'd26;
    localparam int         LETTER_W_DEF = 5;
    localparam int         LIVES_W      = 4;

endpackage

// File: rtl/hangman_lives.sv
// Lives counter for one hangman round; with HANGMAN_BONUS_EN a hit streak
// of STREAK_LEN restores one life (saturating at LIVES).
module hangman_lives
    import hangman_pkg::*;
#(
    parameter int LIVES      = 4,
    parameter int STREAK_LEN = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart_i,
    input  logic               hit_i,
    input  logic               miss_i,
    input  logic               win_i,
    output logic [LIVES_W-1:0] lives_o,
    output logic [LIVES_W-1:0] lives_next_o,
    output logic               bonus_o
);

    localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(LIVES);

    logic [LIVES_W-1:0] lives_q, lives_d;

`ifdef HANGMAN_BONUS_EN
    localparam int            SW         = $clog2(STREAK_LEN + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_LEN);

    logic [SW-1:0] streak_q, streak_d;
    logic          grant, bonus_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lives_d  = lives_q;
        streak_d = streak_q;
        grant    = 1'b0;
        if (miss_i) begin
            if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            streak_d = '0;
        end else if (hit_i) begin
            streak_d = streak_q + SW'(1);
            // The winning hit ends the round, so no bonus is awarded on it.
            if (!win_i && streak_d == STREAK_TOP) begin
                grant    = 1'b1;
                streak_d = '0;
                if (lives_q != LIVES_MAX) lives_d = lives_q + LIVES_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart_i) begin
            lives_q  <= LIVES_MAX;
            streak_q <= '0;
            bonus_q  <= 1'b0;
        end else begin
            lives_q  <= lives_d;
            streak_q <= streak_d;
            bonus_q  <= grant;
        end
    end

    assign bonus_o = bonus_q;
`else
    always_comb begin
        lives_d = lives_q;
        if (miss_i && lives_q != '0) lives_d = lives_q - LIVES_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || restart_i) lives_q <= LIVES_MAX;
        else                    lives_q <= lives_d;
    end

    assign bonus_o = 1'b0;
`endif

    assign lives_o      = lives_q;
    assign lives_next_o = lives_d;

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: IDLE/PLAY/WON/LOST flow, guessed-letter set and
// outcome pulses. Streak bonus lives are enabled by defining HANGMAN_BONUS_EN.
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int ALPHABET   = int'(START_CODE),
    parameter int LETTER_W   = LETTER_W_DEF,
    parameter int LIVES      = 4,
    parameter int STREAK_LEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ALPHABET-1:0] word_mask,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_letter,
    output logic [1:0]          state,
    output logic [ALPHABET-1:0] guessed,
    output logic [ALPHABET-1:0] revealed,
    output logic [3:0]          lives_left,
    output logic                guess_hit,
    output logic                guess_miss,
    output logic                guess_repeat,
    output logic                bonus_life
);

    localparam logic [LETTER_W-1:0] CODE_LIMIT = LETTER_W'(ALPHABET);

    state_e              state_q;
    logic [ALPHABET-1:0] guessed_q, guessed_d, mask_q, letter_oh;
    logic                hit_q, miss_q, repeat_q;
    logic                restart, accept, is_repeat, is_hit, is_miss, won_d;
    logic [LIVES_W-1:0]  lives_next;

    always_comb begin
        letter_oh = {{(ALPHABET-1){1'b0}}, 1'b1} << key_letter;
        restart   = start && (state_q != ST_PLAY);
        // A start pulse always swallows a coincident key.
        accept    = (state_q == ST_PLAY) && key_valid && !start && (key_letter < CODE_LIMIT);
        is_repeat = accept && |(guessed_q & letter_oh);
        is_hit    = accept && !is_repeat && |(mask_q & letter_oh);
        is_miss   = accept && !is_repeat && !is_hit;
        guessed_d = (is_hit || is_miss) ? (guessed_q | letter_oh) : guessed_q;
        won_d     = (guessed_d & mask_q) == mask_q;
    end

    hangman_lives #(
        .LIVES      (LIVES),
        .STREAK_LEN (STREAK_LEN)
    ) u_lives (
        .clk          (clk),
        .reset        (reset),
        .restart_i    (restart),
        .hit_i        (is_hit),
        .miss_i       (is_miss),
        .win_i        (won_d),
        .lives_o      (lives_left),
        .lives_next_o (lives_next),
        .bonus_o      (bonus_life)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            guessed_q <= '0;
            mask_q    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            hit_q    <= is_hit;
            miss_q   <= is_miss;
            repeat_q <= is_repeat;
            case (state_q)
                ST_PLAY: begin
                    guessed_q <= guessed_d;
                    // Terminal check sees this edge's guess; a full reveal beats zero lives.
                    if (won_d)                 state_q <= ST_WON;
                    else if (lives_next == '0) state_q <= ST_LOST;
                end
                default: begin
                    if (start) begin
                        state_q   <= ST_PLAY;
                        mask_q    <= word_mask;
                        guessed_q <= '0;
                    end
                end
            endcase
        end
    end

    assign state        = state_q;
    assign guessed      = guessed_q;
    assign revealed     = guessed_q & mask_q;
    assign guess_hit    = hit_q;
    assign guess_miss   = miss_q;
    assign guess_repeat = repeat_q;

endmodule
